// File: rtl/wisc_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: word width, default
// address/tag widths and the quiesce FSM state encoding.
package wisc_mem_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_TAG_W   = 2;
    localparam int unsigned LATENCY_MAX = 8;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } mem_state_e;

endpackage

// File: rtl/rsp_pipe_stage.sv
// One register stage of the read-response pipeline; reset clears only the
// valid bit so the data path carries no reset load.
module rsp_pipe_stage
    import wisc_mem_pkg::*;
#(
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prev_valid,
    input  logic [WORD_W-1:0] prev_data,
    input  logic [TAG_W-1:0]  prev_tag,
    output logic              valid,
    output logic [WORD_W-1:0] data,
    output logic [TAG_W-1:0]  tag
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else begin
            valid <= prev_valid;
        end
    end

    // Payload only moves with a live beat
    always_ff @(posedge clk) begin
        if (prev_valid) begin
            data <= prev_data;
            tag  <= prev_tag;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: word array with fixed-latency pipelined reads,
// posted writes and a drain/halt handshake for quiescing before hlt.
module data_mem_responder
    import wisc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DEPTH   = 2 ** (ADDR_W - 1),
    parameter int unsigned LATENCY = 4,
    parameter int unsigned TAG_W   = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic [TAG_W-1:0]  rsp_tag,
    input  logic              drain_req,
    output logic              idle
);

    localparam int unsigned IDX_W = ADDR_W - 1;

    if (LATENCY == 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be within 1..8");
    end

    mem_state_e state, state_next;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              busy;
    logic              unused_addr_lsb;

    // Element 0 is the beat being captured this cycle; element i is stage i's output
    logic              pipe_valid [LATENCY];
    logic [WORD_W-1:0] pipe_data  [LATENCY];
    logic [TAG_W-1:0]  pipe_tag   [LATENCY];

    assign idx             = req_addr[ADDR_W-1:1];
    assign unused_addr_lsb = req_addr[0];
    assign req_ready       = (state == RUN);
    assign accept          = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (accept && req_wr) begin
            mem[idx] <= req_wdata;
        end
    end

    assign pipe_valid[0] = accept & ~req_wr;
    assign pipe_data[0]  = mem[idx];
    assign pipe_tag[0]   = req_tag;

    for (genvar i = 1; i < LATENCY; i++) begin : g_stage
        rsp_pipe_stage #(
            .TAG_W (TAG_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (pipe_valid[i-1]),
            .prev_data  (pipe_data[i-1]),
            .prev_tag   (pipe_tag[i-1]),
            .valid      (pipe_valid[i]),
            .data       (pipe_data[i]),
            .tag        (pipe_tag[i])
        );
    end

    // Reads still in the registered stages; the output register is not counted
    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            busy = busy | pipe_valid[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (drain_req) state_next = DRAIN;
            DRAIN:   if (!busy)     state_next = HALTED;
            HALTED:  if (!drain_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Response register holds its payload between pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_tag   <= '0;
            idle      <= 1'b0;
        end else begin
            rsp_valid <= pipe_valid[LATENCY-1];
            if (pipe_valid[LATENCY-1]) begin
                rsp_rdata <= pipe_data[LATENCY-1];
                rsp_tag   <= pipe_tag[LATENCY-1];
            end
            idle <= (state_next == HALTED);
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=4): latency, ordering,
// snapshot semantics, address aliasing, drain/halt and reset discard.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_tag;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_tag;
    logic        drain_req;
    logic        idle;

    int tests;
    int fails;

    data_mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_tag   (rsp_tag),
        .drain_req (drain_req),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next cycle; inputs and checks happen 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] t);
        req_valid = v;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = wd;
        req_tag   = t;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_rsp(input string name, input logic v, input logic [15:0] d,
                           input logic [1:0] t);
        check({name, ".valid"}, 32'(rsp_valid), 32'(v));
        check({name, ".rdata"}, 32'(rsp_rdata), 32'(d));
        check({name, ".tag"},   32'(rsp_tag),   32'(t));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        drain_req = 1'b0;
        nop();

        // Reset
        tick();
        tick();
        chk_rsp("reset", 1'b0, 16'h0000, 2'd0);
        check("reset.idle",  32'(idle), 32'd0);
        check("reset.ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // Preload words used later
        tick(); drive(1'b1, 1'b1, 16'h0000, 16'h1111, 2'd0);
        tick(); drive(1'b1, 1'b1, 16'h0002, 16'h2222, 2'd0);
        tick(); drive(1'b1, 1'b1, 16'h0004, 16'h3333, 2'd0);
        tick(); drive(1'b1, 1'b1, 16'h0020, 16'hAAAA, 2'd0);

        // Store then load same word: response exactly 4 cycles after the load
        tick(); drive(1'b1, 1'b1, 16'h0010, 16'h1234, 2'd0);
        tick(); drive(1'b1, 1'b0, 16'h0010, 16'h0000, 2'd3);
        tick(); nop();
        tick();
        tick(); chk_rsp("lat.early", 1'b0, 16'h0000, 2'd0);
        tick(); chk_rsp("lat.rsp",   1'b1, 16'h1234, 2'd3);
        tick(); chk_rsp("lat.hold",  1'b0, 16'h1234, 2'd3);

        // Back-to-back loads return in order, one per cycle
        tick(); drive(1'b1, 1'b0, 16'h0000, 16'h0000, 2'd0);
        tick(); drive(1'b1, 1'b0, 16'h0002, 16'h0000, 2'd1);
        tick(); drive(1'b1, 1'b0, 16'h0004, 16'h0000, 2'd2);
        tick(); nop(); chk_rsp("b2b.pre", 1'b0, 16'h1234, 2'd3);
        tick(); chk_rsp("b2b.r0", 1'b1, 16'h1111, 2'd0);
        tick(); chk_rsp("b2b.r1", 1'b1, 16'h2222, 2'd1);
        tick(); chk_rsp("b2b.r2", 1'b1, 16'h3333, 2'd2);
        tick(); chk_rsp("b2b.post", 1'b0, 16'h3333, 2'd2);

        // Load snapshot is not disturbed by a following store to the same word
        tick(); drive(1'b1, 1'b0, 16'h0020, 16'h0000, 2'd1);
        tick(); drive(1'b1, 1'b1, 16'h0020, 16'h5555, 2'd0);
        tick(); drive(1'b1, 1'b0, 16'h0020, 16'h0000, 2'd2);
        tick(); nop(); chk_rsp("snap.pre", 1'b0, 16'h3333, 2'd2);
        tick(); chk_rsp("snap.old", 1'b1, 16'hAAAA, 2'd1);
        tick(); chk_rsp("snap.gap", 1'b0, 16'hAAAA, 2'd1);
        tick(); chk_rsp("snap.new", 1'b1, 16'h5555, 2'd2);

        // Odd address aliases the even word below
        tick(); drive(1'b1, 1'b1, 16'h0031, 16'hBEEF, 2'd0);
        tick(); drive(1'b1, 1'b0, 16'h0030, 16'h0000, 2'd0);
        tick(); nop();
        tick();
        tick(); chk_rsp("alias.pre", 1'b0, 16'h5555, 2'd2);
        tick(); chk_rsp("alias.rsp", 1'b1, 16'hBEEF, 2'd0);

        // Drain with two loads in flight; a request during DRAIN is ignored
        tick(); drive(1'b1, 1'b0, 16'h0000, 16'h0000, 2'd1);
        tick(); drive(1'b1, 1'b0, 16'h0002, 16'h0000, 2'd2); drain_req = 1'b1;
        tick(); drive(1'b1, 1'b0, 16'h0004, 16'h0000, 2'd3);
        check("drain.ready", 32'(req_ready), 32'd0);
        tick(); nop();
        check("drain.idle0", 32'(idle), 32'd0);
        tick(); chk_rsp("drain.r0", 1'b1, 16'h1111, 2'd1);
        check("drain.idle1", 32'(idle), 32'd0);
        tick(); chk_rsp("drain.r1", 1'b1, 16'h2222, 2'd2);
        check("drain.idle2", 32'(idle), 32'd0);
        tick(); chk_rsp("halt.norsp", 1'b0, 16'h2222, 2'd2);
        check("halt.idle",  32'(idle), 32'd1);
        check("halt.ready", 32'(req_ready), 32'd0);
        tick(); drain_req = 1'b0;
        chk_rsp("halt.norsp2", 1'b0, 16'h2222, 2'd2);
        check("halt.idle2",  32'(idle), 32'd1);
        check("halt.ready2", 32'(req_ready), 32'd0);
        tick();
        check("resume.ready", 32'(req_ready), 32'd1);
        check("resume.idle",  32'(idle), 32'd0);

        // Reset discards an outstanding read; array contents survive
        tick(); drive(1'b1, 1'b0, 16'h0010, 16'h0000, 2'd2);
        tick(); nop();
        tick(); rst_n = 1'b0;
        tick();
        chk_rsp("rst.out", 1'b0, 16'h0000, 2'd0);
        check("rst.idle", 32'(idle), 32'd0);
        tick(); rst_n = 1'b1;
        chk_rsp("rst.discard", 1'b0, 16'h0000, 2'd0);
        tick(); drive(1'b1, 1'b0, 16'h0020, 16'h0000, 2'd1);
        chk_rsp("rst.discard2", 1'b0, 16'h0000, 2'd0);
        tick(); nop();
        tick();
        tick(); chk_rsp("rst.quiet", 1'b0, 16'h0000, 2'd0);
        tick(); chk_rsp("rst.keep", 1'b1, 16'h5555, 2'd1);
        tick(); chk_rsp("rst.after", 1'b0, 16'h5555, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
